phase_convergence_monitor: RTL and testbench

- Sits directly downstream of the phase sampler.
- Consumes the per-spin phase vector (1 = in phase with local field, 0 = out of phase) once per clk.
- Decides when the Ising machine has converged: the vector is unchanged for a programmable number of consecutive cycles, or a run timeout expires.
- Captures a snapshot and presents it on a valid/ready result interface to the readout/host logic.

---
 rtl/ising_pkg.sv | 16 +
 rtl/popcount.sv | 17 +
 rtl/phase_convergence_monitor.sv | 146 ++++++++++++++
 tb/tb_phase_convergence_monitor.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ising_pkg.sv
// rtl/ising_pkg.sv - shared state encoding, counter width and saturating increment for the phase monitor
package ising_pkg;

   localparam int CNT_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/popcount.sv
// rtl/popcount.sv - combinational count of set bits in an N-bit vector
module popcount #(
   parameter int N  = 3,
   parameter int CW = $clog2(N + 1)
) (
   input  logic [N-1:0]  in_bits,
   output logic [CW-1:0] cnt
);

   always_comb begin
      cnt = '0;
      for (int i = 0; i < N; i++) begin
         cnt = cnt + CW'(in_bits[i]);
      end
   end

endmodule

// File: rtl/phase_convergence_monitor.sv
// rtl/phase_convergence_monitor.sv - detects phase-vector convergence or run timeout and offers a snapshot
// FLIP_COUNT_EN adds result_flips, the accumulated per-cycle phase flip count of the run.
module phase_convergence_monitor
   import ising_pkg::*;
#(
   parameter int N        = 3,
   parameter int STABLE_W = 16
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                start,
   input  logic [STABLE_W-1:0] stable_cycles,
   input  logic [CNT_W-1:0]    timeout_cycles,
   input  logic [N-1:0]        phase,
   output logic                busy,
   output logic                result_valid,
   input  logic                result_ready,
   output logic [N-1:0]        result_phase,
   output logic                result_timeout,
   output logic [CNT_W-1:0]    result_cycles
`ifdef FLIP_COUNT_EN
  ,output logic [CNT_W-1:0]    result_flips
`endif
);

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      run_cnt_q, run_cnt_d;
   logic [STABLE_W-1:0]   stab_cnt_q, stab_cnt_d;
   logic [N-1:0]          prev_phase_q, prev_phase_d;
   logic [N-1:0]          result_phase_q, result_phase_d;
   logic                  result_timeout_q, result_timeout_d;
   logic [CNT_W-1:0]      result_cycles_q, result_cycles_d;

   logic                  match, conv, tmo;
   logic [STABLE_W-1:0]   stab_nxt;
   logic [CNT_W-1:0]      run_nxt;

`ifdef FLIP_COUNT_EN
   localparam int PW = $clog2(N + 1);
   logic [CNT_W-1:0]      flips_q, flips_d, flips_nxt;
   logic [CNT_W-1:0]      result_flips_q, result_flips_d;
   logic [PW-1:0]         flip_pop;
   logic [CNT_W:0]        flip_sum;

   popcount #(.N(N), .CW(PW)) u_popcount (
      .in_bits (phase ^ prev_phase_q),
      .cnt     (flip_pop)
   );

   assign flip_sum     = {1'b0, flips_q} + (CNT_W + 1)'(flip_pop);
   assign flips_nxt    = flip_sum[CNT_W] ? '1 : flip_sum[CNT_W-1:0];
   assign result_flips = result_flips_q;
`endif

   assign match    = (phase == prev_phase_q);
   assign stab_nxt = match ? ((&stab_cnt_q) ? stab_cnt_q : stab_cnt_q + 1'b1) : '0;
   assign run_nxt  = sat_inc(run_cnt_q);
   assign conv     = (stab_nxt >= stable_cycles);
   assign tmo      = (timeout_cycles != '0) && (run_nxt >= timeout_cycles);

   always_comb begin
      state_d          = state_q;
      run_cnt_d        = run_cnt_q;
      stab_cnt_d       = stab_cnt_q;
      prev_phase_d     = prev_phase_q;
      result_phase_d   = result_phase_q;
      result_timeout_d = result_timeout_q;
      result_cycles_d  = result_cycles_q;
`ifdef FLIP_COUNT_EN
      flips_d          = flips_q;
      result_flips_d   = result_flips_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               prev_phase_d = phase;
               run_cnt_d    = '0;
               stab_cnt_d   = '0;
`ifdef FLIP_COUNT_EN
               flips_d      = '0;
`endif
               state_d      = RUN;
            end
         end
         RUN: begin
            prev_phase_d = phase;
            run_cnt_d    = run_nxt;
            stab_cnt_d   = stab_nxt;
`ifdef FLIP_COUNT_EN
            flips_d      = flips_nxt;
`endif
            // convergence takes precedence when both conditions hit together
            if (conv || tmo) begin
               result_phase_d   = phase;
               result_cycles_d  = run_nxt;
               result_timeout_d = !conv && tmo;
`ifdef FLIP_COUNT_EN
               result_flips_d   = flips_nxt;
`endif
               state_d          = HOLD;
            end
         end
         HOLD: begin
            if (result_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q          <= IDLE;
         run_cnt_q        <= '0;
         stab_cnt_q       <= '0;
         prev_phase_q     <= '0;
         result_phase_q   <= '0;
         result_timeout_q <= 1'b0;
         result_cycles_q  <= '0;
`ifdef FLIP_COUNT_EN
         flips_q          <= '0;
         result_flips_q   <= '0;
`endif
      end else begin
         state_q          <= state_d;
         run_cnt_q        <= run_cnt_d;
         stab_cnt_q       <= stab_cnt_d;
         prev_phase_q     <= prev_phase_d;
         result_phase_q   <= result_phase_d;
         result_timeout_q <= result_timeout_d;
         result_cycles_q  <= result_cycles_d;
`ifdef FLIP_COUNT_EN
         flips_q          <= flips_d;
         result_flips_q   <= result_flips_d;
`endif
      end
   end

   assign busy           = (state_q != IDLE);
   assign result_valid   = (state_q == HOLD);
   assign result_phase   = result_phase_q;
   assign result_timeout = result_timeout_q;
   assign result_cycles  = result_cycles_q;

endmodule

// File: tb/tb_phase_convergence_monitor.sv
// tb/tb_phase_convergence_monitor.sv - directed self-checking bench for phase_convergence_monitor
module tb_phase_convergence_monitor;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start = 1'b0;
   logic [15:0] stable_cycles = '0;
   logic [31:0] timeout_cycles = '0;
   logic [2:0]  phase = '0;
   logic        busy;
   logic        result_valid;
   logic        result_ready = 1'b0;
   logic [2:0]  result_phase;
   logic        result_timeout;
   logic [31:0] result_cycles;
`ifdef FLIP_COUNT_EN
   logic [31:0] result_flips;
`endif

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   phase_convergence_monitor #(.N(3), .STABLE_W(16)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .start          (start),
      .stable_cycles  (stable_cycles),
      .timeout_cycles (timeout_cycles),
      .phase          (phase),
      .busy           (busy),
      .result_valid   (result_valid),
      .result_ready   (result_ready),
      .result_phase   (result_phase),
      .result_timeout (result_timeout),
      .result_cycles  (result_cycles)
`ifdef FLIP_COUNT_EN
     ,.result_flips   (result_flips)
`endif
   );

   // Leaves the bench at the falling edge just after the start-accepting rising edge.
   task automatic start_run(input logic [2:0] p);
      @(negedge clk);
      phase = p;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset;
      #1;
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b exp 0", busy); end
      compared++; if (result_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b exp 0", result_valid); end
      compared++; if (result_phase !== 3'b000) begin mismatched++; $display("FAIL reset_phase got %b exp 000", result_phase); end
      compared++; if (result_timeout !== 1'b0) begin mismatched++; $display("FAIL reset_timeout got %b exp 0", result_timeout); end
      compared++; if (result_cycles !== 32'd0) begin mismatched++; $display("FAIL reset_cycles got %0d exp 0", result_cycles); end
`ifdef FLIP_COUNT_EN
      compared++; if (result_flips !== 32'd0) begin mismatched++; $display("FAIL reset_flips got %0d exp 0", result_flips); end
`endif
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_min_latency;
      stable_cycles = 16'd0; timeout_cycles = 32'd0;
      start_run(3'b011);
      compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL lat_busy got %b exp 1", busy); end
      compared++; if (result_valid !== 1'b0) begin mismatched++; $display("FAIL lat_valid_early got %b exp 0", result_valid); end
      phase = 3'b110;
      @(negedge clk);
      compared++; if (result_valid !== 1'b1) begin mismatched++; $display("FAIL lat_valid got %b exp 1", result_valid); end
      compared++; if (result_cycles !== 32'd1) begin mismatched++; $display("FAIL lat_cycles got %0d exp 1", result_cycles); end
      compared++; if (result_phase !== 3'b110) begin mismatched++; $display("FAIL lat_phase got %b exp 110", result_phase); end
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
   endtask

   task automatic test_convergence;
      stable_cycles = 16'd4; timeout_cycles = 32'd0;
      start_run(3'b101);
      for (int i = 1; i <= 4; i++) begin
         phase = 3'b101;
         @(negedge clk);
         if (i < 4) begin
            compared++; if (result_valid !== 1'b0) begin mismatched++; $display("FAIL conv_valid_early cycle %0d got %b exp 0", i, result_valid); end
         end
      end
      compared++; if (result_valid !== 1'b1) begin mismatched++; $display("FAIL conv_valid got %b exp 1", result_valid); end
      compared++; if (result_phase !== 3'b101) begin mismatched++; $display("FAIL conv_phase got %b exp 101", result_phase); end
      compared++; if (result_cycles !== 32'd4) begin mismatched++; $display("FAIL conv_cycles got %0d exp 4", result_cycles); end
      compared++; if (result_timeout !== 1'b0) begin mismatched++; $display("FAIL conv_timeout got %b exp 0", result_timeout); end
`ifdef FLIP_COUNT_EN
      compared++; if (result_flips !== 32'd0) begin mismatched++; $display("FAIL conv_flips got %0d exp 0", result_flips); end
`endif
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL conv_busy_after got %b exp 0", busy); end
   endtask

   task automatic test_instability;
      stable_cycles = 16'd3; timeout_cycles = 32'd0;
      start_run(3'b000);
      for (int i = 1; i <= 4; i++) begin
         phase = 3'b001;
         @(negedge clk);
         if (i < 4) begin
            compared++; if (result_valid !== 1'b0) begin mismatched++; $display("FAIL inst_valid_early cycle %0d got %b exp 0", i, result_valid); end
         end
      end
      compared++; if (result_valid !== 1'b1) begin mismatched++; $display("FAIL inst_valid got %b exp 1", result_valid); end
      compared++; if (result_cycles !== 32'd4) begin mismatched++; $display("FAIL inst_cycles got %0d exp 4", result_cycles); end
      compared++; if (result_phase !== 3'b001) begin mismatched++; $display("FAIL inst_phase got %b exp 001", result_phase); end
`ifdef FLIP_COUNT_EN
      compared++; if (result_flips !== 32'd1) begin mismatched++; $display("FAIL inst_flips got %0d exp 1", result_flips); end
`endif
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
   endtask

   task automatic test_timeout;
      stable_cycles = 16'd10; timeout_cycles = 32'd6;
      start_run(3'b010);
      for (int i = 1; i <= 6; i++) begin
         phase = (i % 2 == 1) ? 3'b101 : 3'b010;
         @(negedge clk);
         if (i < 6) begin
            compared++; if (result_valid !== 1'b0) begin mismatched++; $display("FAIL tmo_valid_early cycle %0d got %b exp 0", i, result_valid); end
         end
      end
      compared++; if (result_valid !== 1'b1) begin mismatched++; $display("FAIL tmo_valid got %b exp 1", result_valid); end
      compared++; if (result_timeout !== 1'b1) begin mismatched++; $display("FAIL tmo_flag got %b exp 1", result_timeout); end
      compared++; if (result_cycles !== 32'd6) begin mismatched++; $display("FAIL tmo_cycles got %0d exp 6", result_cycles); end
      compared++; if (result_phase !== 3'b010) begin mismatched++; $display("FAIL tmo_phase got %b exp 010", result_phase); end
`ifdef FLIP_COUNT_EN
      compared++; if (result_flips !== 32'd18) begin mismatched++; $display("FAIL tmo_flips got %0d exp 18", result_flips); end
`endif
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
   endtask

   task automatic test_tie;
      stable_cycles = 16'd5; timeout_cycles = 32'd5;
      start_run(3'b111);
      for (int i = 1; i <= 5; i++) begin
         phase = 3'b111;
         @(negedge clk);
      end
      compared++; if (result_valid !== 1'b1) begin mismatched++; $display("FAIL tie_valid got %b exp 1", result_valid); end
      compared++; if (result_timeout !== 1'b0) begin mismatched++; $display("FAIL tie_timeout got %b exp 0", result_timeout); end
      compared++; if (result_cycles !== 32'd5) begin mismatched++; $display("FAIL tie_cycles got %0d exp 5", result_cycles); end
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
   endtask

   task automatic test_backpressure;
      stable_cycles = 16'd2; timeout_cycles = 32'd0;
      start_run(3'b011);
      phase = 3'b011;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         start = (i == 3);
         phase = 3'(i);
         @(negedge clk);
      end
      start = 1'b0;
      compared++; if (result_valid !== 1'b1) begin mismatched++; $display("FAIL bp_valid got %b exp 1", result_valid); end
      compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL bp_busy got %b exp 1", busy); end
      compared++; if (result_phase !== 3'b011) begin mismatched++; $display("FAIL bp_phase got %b exp 011", result_phase); end
      compared++; if (result_cycles !== 32'd2) begin mismatched++; $display("FAIL bp_cycles got %0d exp 2", result_cycles); end
      result_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      start = 1'b0;
      compared++; if (result_valid !== 1'b0) begin mismatched++; $display("FAIL bp_valid_after got %b exp 0", result_valid); end
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL bp_busy_after got %b exp 0", busy); end
      @(negedge clk);
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL bp_start_dropped got %b exp 0", busy); end
      compared++; if (result_cycles !== 32'd2) begin mismatched++; $display("FAIL bp_cycles_kept got %0d exp 2", result_cycles); end
   endtask

   task automatic test_async_reset;
      stable_cycles = 16'd10; timeout_cycles = 32'd0;
      start_run(3'b100);
      @(negedge clk);
      #2;
      rstn = 1'b0;
      #1;
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL arst_busy got %b exp 0", busy); end
      compared++; if (result_valid !== 1'b0) begin mismatched++; $display("FAIL arst_valid got %b exp 0", result_valid); end
      compared++; if (result_cycles !== 32'd0) begin mismatched++; $display("FAIL arst_cycles got %0d exp 0", result_cycles); end
      @(negedge clk);
      rstn = 1'b1;
      stable_cycles = 16'd1;
      start_run(3'b110);
      phase = 3'b110;
      @(negedge clk);
      compared++; if (result_valid !== 1'b1) begin mismatched++; $display("FAIL arst_rerun_valid got %b exp 1", result_valid); end
      compared++; if (result_cycles !== 32'd1) begin mismatched++; $display("FAIL arst_rerun_cycles got %0d exp 1", result_cycles); end
      compared++; if (result_phase !== 3'b110) begin mismatched++; $display("FAIL arst_rerun_phase got %b exp 110", result_phase); end
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL arst_rerun_idle got %b exp 0", busy); end
   endtask

   initial begin
      test_reset();
      test_min_latency();
      test_convergence();
      test_instability();
      test_timeout();
      test_tie();
      test_backpressure();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
